// File: rtl/hazard_scheduler_if.sv
// Hazard scheduler bundle: decoded pipeline fields in,
// stall/flush/forward controls out.
interface hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic [4:0]       rd_m;
  logic [4:0]       rd_w;
  logic             regwrite_e;
  logic             regwrite_m;
  logic             regwrite_w;
  logic             wb_sel_e;
  logic             pc_src_e;
  logic             dmem_req_m;
  logic             dmem_ready;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e,
    output rd_e, rd_m, rd_w,
    output regwrite_e, regwrite_m, regwrite_w,
    output wb_sel_e, pc_src_e,
    output dmem_req_m, dmem_ready,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w,
    input  fwd_a_e, fwd_b_e,
    input  mem_timeout, stall_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e,
    input  rd_e, rd_m, rd_w,
    input  regwrite_e, regwrite_m, regwrite_w,
    input  wb_sel_e, pc_src_e,
    input  dmem_req_m, dmem_ready,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w,
    output fwd_a_e, fwd_b_e,
    output mem_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Stall/flush/forward sequencing for the 5-stage RV32I pipe:
// boot flush, dmem wait with timeout, stall-cycle counter.
module hazard_scheduler #(
  parameter int BOOT_CYCLES = 2,
  parameter int MAX_WAIT    = 15,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scheduler_if.slave bus
);
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_PRE  = WW'(MAX_WAIT - 1);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [BW-1:0]    r_boot;
  logic [WW-1:0]    r_wait;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic       w_mem;
  logic       w_lu;
  logic       w_hold;
  logic       w_rules;
  logic [1:0] w_next;
  logic       w_sf, w_sd, w_se, w_sm;
  logic       w_fd, w_fe, w_fw;

  assign w_mem = bus.dmem_req_m & ~bus.dmem_ready;
  assign w_lu  = bus.wb_sel_e & bus.regwrite_e
               & (bus.rd_e != 5'd0)
               & ((bus.rd_e == bus.rs1_d)
               | (bus.rd_e == bus.rs2_d));

  assign w_hold  = ((r_state == S_RUN) & w_mem)
                 | ((r_state == S_WAIT) & ~bus.dmem_ready);
  assign w_rules = ((r_state == S_RUN) & ~w_mem)
                 | ((r_state == S_WAIT) & bus.dmem_ready);

  always_comb begin
    w_sf   = 1'b0;
    w_sd   = 1'b0;
    w_se   = 1'b0;
    w_sm   = 1'b0;
    w_fd   = 1'b0;
    w_fe   = 1'b0;
    w_fw   = 1'b0;
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_BOOT): begin
        w_sf = 1'b1;
        w_fd = 1'b1;
        w_fe = 1'b1;
        w_fw = 1'b1;
        if (r_boot == BOOT_LAST) w_next = S_RUN;
      end
      w_hold: begin
        w_sf   = 1'b1;
        w_sd   = 1'b1;
        w_se   = 1'b1;
        w_sm   = 1'b1;
        w_fw   = 1'b1;
        w_next = S_WAIT;
      end
      w_rules: begin
        // a redirect squashes D anyway, so load-use is moot
        if (bus.pc_src_e) begin
          w_fd = 1'b1;
          w_fe = 1'b1;
        end else if (w_lu) begin
          w_sf = 1'b1;
          w_sd = 1'b1;
          w_fe = 1'b1;
        end
        w_next = S_RUN;
      end
      default: w_next = S_BOOT;
    endcase
  end

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] x,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    if (we_m && rd_m != 5'd0 && rd_m == x)
      return 2'b10;
    if (we_w && rd_w != 5'd0 && rd_w == x)
      return 2'b01;
    return 2'b00;
  endfunction

  assign bus.fwd_a_e = fwd_sel(bus.rs1_e,
    bus.regwrite_m, bus.rd_m, bus.regwrite_w, bus.rd_w);
  assign bus.fwd_b_e = fwd_sel(bus.rs2_e,
    bus.regwrite_m, bus.rd_m, bus.regwrite_w, bus.rd_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_BOOT;
      r_boot    <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      r_boot  <= (r_state == S_BOOT) ? r_boot + BW'(1) : '0;
      if ((r_state == S_RUN) & w_mem)
        r_wait <= WW'(1);
      else if (w_hold)
        r_wait <= (r_wait == WAIT_MAX) ? r_wait
                                       : r_wait + WW'(1);
      else
        r_wait <= '0;
      // flag on the edge where the count lands on MAX_WAIT
      if ((r_state == S_WAIT) & w_hold & (r_wait >= WAIT_PRE))
        r_timeout <= 1'b1;
      if (w_sf & (r_state != S_BOOT) & (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_f     = w_sf;
  assign bus.stall_d     = w_sd;
  assign bus.stall_e     = w_se;
  assign bus.stall_m     = w_sm;
  assign bus.flush_d     = w_fd;
  assign bus.flush_e     = w_fe;
  assign bus.flush_w     = w_fw;
  assign bus.mem_timeout = r_timeout;
  assign bus.stall_cnt   = r_cnt;
endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core: generates stall, flush and forwarding controls for the F/D/E/M/W pipeline registers.
- Consumes decoded control fields that the main decoder produces and that travel down the pipeline: regwrite_en, wb_sel, branch/jump resolution.
- Holds a boot-flush FSM, a data-memory wait FSM with timeout, and a saturating stall-cycle counter.
- Sits beside the datapath. All its outputs drive pipeline register enables and clears, or the forwarding muxes.

Parameters:
- BOOT_CYCLES, 2: cycles after reset release during which the pipeline is held flushed.
- MAX_WAIT, 15: maximum consecutive dmem wait cycles before mem_timeout is set.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_d, rs2_d  in  5  source registers of the instruction in D.
- rs1_e, rs2_e  in  5  source registers of the instruction in E.
- rd_e, rd_m, rd_w  in  5  destination registers in E/M/W.
- regwrite_e, regwrite_m, regwrite_w  in  1  regwrite_en piped to E/M/W.
- wb_sel_e  in  1  1 = instruction in E is a load (result comes from memory).
- pc_src_e  in  1  taken branch or jump resolved in E.
- dmem_req_m  in  1  load/store active in M.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the respective pipeline register.
- flush_d, flush_e, flush_w  out  1  insert a bubble into D/E/W.
- fwd_a_e, fwd_b_e  out  2  forwarding select: 00 = regfile, 01 = W result, 10 = M result.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  saturating count of stall_f-high cycles.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=BOOT, boot counter=0, wait counter=0, mem_timeout=0, stall_cnt=0.
  - Outputs during reset: stall_f=1, flush_d=1, flush_e=1, flush_w=1; all other stalls 0; fwd=00.
- FSM states BOOT, RUN, MEM_WAIT:
  - BOOT: stall_f=1, flush_d=flush_e=flush_w=1. After BOOT_CYCLES clocks, go to RUN.
  - RUN, checked in this priority order:
    - 1) Memory stall: dmem_req_m & !dmem_ready. Assert stall_f/d/e/m and flush_w in the same cycle (combinational). Next state is MEM_WAIT, wait counter=1. pc_src_e and load-use are ignored this cycle.
    - 2) Redirect: pc_src_e. Assert flush_d and flush_e, no stalls. A load-use condition in the same cycle is suppressed.
    - 3) Load-use: wb_sel_e & regwrite_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d). Assert stall_f, stall_d and flush_e for exactly that cycle.
  - MEM_WAIT:
    - While !dmem_ready: stall_f/d/e/m=1, flush_w=1, wait counter increments (saturates at MAX_WAIT).
    - When the counter reaches MAX_WAIT with dmem_ready still 0: set mem_timeout (sticky until reset) and remain in MEM_WAIT.
    - On dmem_ready=1: outputs are the RUN rules 2/3 evaluated that cycle (no memory stall), counter clears, next state is RUN.
    - A redirect pending in E during the wait takes effect on the release cycle.
- Forwarding (combinational, all states), per operand X in {rs1_e, rs2_e}:
  - 10 if regwrite_m & rd_m!=0 & rd_m==X.
  - else 01 if regwrite_w & rd_w!=0 & rd_w==X.
  - else 00.
  - M has priority over W. x0 is never forwarded.
- stall_cnt: increments on each clock with stall_f=1 in RUN or MEM_WAIT (BOOT is not counted). Saturates at all-ones, no wrap.
- Reset mid-wait: returns immediately to BOOT. mem_timeout and stall_cnt clear.

Test Plan:
- Reset release with BOOT_CYCLES=2 -> flushes high for exactly 2 clocks after rst_n rises, then all stalls/flushes 0 with idle inputs; stall_cnt=0.
- Load-use: wb_sel_e=1, regwrite_e=1, rd_e=5, rs2_d=5 -> one cycle of stall_f=stall_d=flush_e=1, stall_cnt=1. Same stimulus with rd_e=0 -> no stall.
- Load-use and pc_src_e=1 in the same cycle -> flush_d=flush_e=1, stall_f=0, stall_cnt unchanged.
- Forwarding: rd_m=rd_w=7, both regwrite=1, rs1_e=7 -> fwd_a_e=10. Then regwrite_m=0 -> 01. Then rs1_e=0 with rd_m=0 -> 00.
- dmem_req_m=1, dmem_ready low for 3 cycles then high -> stall_f/d/e/m=1 for 3 cycles, released on the 4th; stall_cnt=3; mem_timeout=0.
- dmem_ready held low for 20 cycles (MAX_WAIT=15) -> mem_timeout=1 after the 15th wait cycle and stays 1 after ready. stall_cnt shows CNT_W saturation when preloaded near max via a long wait. Asserting rst_n=0 during the wait clears everything asynchronously.
